// File: rtl/fifo_thresh.sv
// fifo_thresh: synchronous valid/ready FIFO with occupancy count,
// programmable almost-full / almost-empty flags and a synchronous flush.
// All status outputs are registered and derived from the next-state count,
// so no input reaches an output combinationally. data_o is show-ahead.
module fifo_thresh #(
    parameter int SIZEDATA   = 32,
    parameter int DEPTHFIFO  = 8,
    parameter int AFULL_LVL  = DEPTHFIFO - 2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            valid_i,
    input  logic [SIZEDATA-1:0]             data_i,
    output logic                            ready_o,
    output logic                            valid_o,
    output logic [SIZEDATA-1:0]             data_o,
    input  logic                            ready_i,
    output logic [$clog2(DEPTHFIFO):0]      count_o,
    output logic                            almost_full_o,
    output logic                            almost_empty_o
);
    localparam int BITSCONT = $clog2(DEPTHFIFO);
    localparam logic [BITSCONT:0] DEPTH_C  = (BITSCONT + 1)'(DEPTHFIFO);
    localparam logic [BITSCONT:0] AFULL_C  = (BITSCONT + 1)'(AFULL_LVL);
    localparam logic [BITSCONT:0] AEMPTY_C = (BITSCONT + 1)'(AEMPTY_LVL);

    // Reject configurations the pointer arithmetic or flag logic cannot honour.
    if (DEPTHFIFO < 2 || (DEPTHFIFO & (DEPTHFIFO - 1)) != 0) begin : g_bad_depth
        $error("fifo_thresh: DEPTHFIFO must be a power of two and >= 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTHFIFO) begin : g_bad_afull
        $error("fifo_thresh: AFULL_LVL must lie in 1..DEPTHFIFO");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTHFIFO - 1) begin : g_bad_aempty
        $error("fifo_thresh: AEMPTY_LVL must lie in 0..DEPTHFIFO-1");
    end

    logic [SIZEDATA-1:0] mem_q [DEPTHFIFO];

    logic [BITSCONT-1:0] wr_ptr_q, wr_ptr_d;
    logic [BITSCONT-1:0] rd_ptr_q, rd_ptr_d;
    logic [BITSCONT:0]   count_q,  count_d;
    logic                ready_q,  ready_d;
    logic                valid_q,  valid_d;
    logic                afull_q,  afull_d;
    logic                aempty_q, aempty_d;

    logic push;
    logic pop;
    logic wr_en;

    // Handshakes use only registered status, so they never form a comb loop.
    assign push  = valid_i && ready_q;
    assign pop   = valid_q && ready_i;
    assign wr_en = push && !flush_i;

    // Next pointers, count and status flags; flush discards any transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        ready_d  = (count_d != DEPTH_C);
        valid_d  = (count_d != '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
    end

    // Control state; ready stays low until the first edge after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // Storage array; contents survive flush and reset (only pointers move).
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o         = mem_q[rd_ptr_q];
    assign ready_o        = ready_q;
    assign valid_o        = valid_q;
    assign count_o        = count_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;

endmodule

// File: tb/tb_fifo_thresh.sv
// Bench for fifo_thresh: queue-based reference model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_fifo_thresh;
    localparam int DW     = 32;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          vin = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rdy_out;
    logic          vout;
    logic [DW-1:0] dout;
    logic          rin = 1'b0;
    logic [3:0]    cnt;
    logic          afull;
    logic          aempty;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    fifo_thresh #(
        .SIZEDATA(DW), .DEPTHFIFO(DEPTH), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .data_i(din),
        .ready_o(rdy_out), .valid_o(vout), .data_o(dout), .ready_i(rin),
        .count_o(cnt), .almost_full_o(afull), .almost_empty_o(aempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: contents as a queue, plus "has seen an edge since reset".
    logic [DW-1:0] mq[$];
    bit            m_live = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_live = 1'b0;
        end else begin
            bit acc;
            bit take;
            acc  = vin && m_live && (mq.size() != DEPTH);
            take = rin && (mq.size() != 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (take) void'(mq.pop_front());
                if (acc) mq.push_back(din);
            end
            m_live = 1'b1;
        end
    end

    // Compare process: every edge (clock or async reset), just after it settles.
    always @(posedge clk or posedge rst) begin
        #1;
        if (chk_en) begin
            chk("m_count", 32'(cnt), 32'(mq.size()));
            chk("m_valid", 32'(vout), 32'(mq.size() != 0));
            chk("m_ready", 32'(rdy_out), 32'(m_live && mq.size() != DEPTH));
            chk("m_afull", 32'(afull), 32'(mq.size() >= AFULL));
            chk("m_aempty", 32'(aempty), 32'(mq.size() <= AEMPTY));
            if (mq.size() != 0) chk("m_data", dout, mq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            vin = 1'b1;
            din = base + DW'(i);
            tick();
        end
        vin = 1'b0;
    endtask

    task automatic drain_expect(input int n, input logic [DW-1:0] base, input string tag);
        rin = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_vld"}, 32'(vout), 32'd1);
            chk({tag, "_data"}, dout, base + DW'(i));
            tick();
        end
        rin = 1'b0;
    endtask

    initial begin
        // Reset asserted between edges: outputs must follow without a clock.
        #3;
        rst = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_valid", 32'(vout), 32'd0);
        chk("rst_ready", 32'(rdy_out), 32'd0);
        chk("rst_aempty", 32'(aempty), 32'd1);
        chk("rst_afull", 32'(afull), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rel_ready_low", 32'(rdy_out), 32'd0);
        tick();
        chk("rel_ready_high", 32'(rdy_out), 32'd1);

        // Fill with 0x11..0x18, then offer 0x19 while full.
        for (int i = 0; i < 8; i++) begin
            vin = 1'b1;
            din = 32'h11 + DW'(i);
            tick();
            chk("fill_count", 32'(cnt), 32'(i + 1));
            chk("fill_aempty", 32'(aempty), 32'(i + 1 <= 1));
            chk("fill_afull", 32'(afull), 32'(i + 1 >= 6));
        end
        chk("full_ready", 32'(rdy_out), 32'd0);
        din = 32'h19;
        tick();
        vin = 1'b0;
        chk("full_count_hold", 32'(cnt), 32'd8);
        drain_expect(8, 32'h11, "drain");
        chk("drain_empty_valid", 32'(vout), 32'd0);
        chk("drain_empty_count", 32'(cnt), 32'd0);

        // Streaming at count 4 across pointer wrap.
        push_n(4, 32'h100);
        vin = 1'b1;
        rin = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 32'h104 + DW'(k);
            chk("stream_data", dout, 32'h100 + DW'(k));
            chk("stream_count", 32'(cnt), 32'd4);
            tick();
        end
        vin = 1'b0;
        rin = 1'b0;
        chk("stream_count_end", 32'(cnt), 32'd4);
        drain_expect(4, 32'h114, "stream_tail");

        // Full with simultaneous push and pop: only the pop happens.
        push_n(8, 32'h200);
        chk("fp_full", 32'(cnt), 32'd8);
        vin = 1'b1;
        rin = 1'b1;
        din = 32'h300;
        tick();
        chk("fp_count7", 32'(cnt), 32'd7);
        chk("fp_ready", 32'(rdy_out), 32'd1);
        din = 32'h301;
        tick();
        vin = 1'b0;
        rin = 1'b0;
        chk("fp_count_keep", 32'(cnt), 32'd7);
        drain_expect(6, 32'h202, "fp_drain");
        drain_expect(1, 32'h301, "fp_last");
        chk("fp_empty", 32'(vout), 32'd0);

        // Flush at count 5 with push and pop requested in the same cycle.
        push_n(5, 32'h400);
        chk("fl_count5", 32'(cnt), 32'd5);
        flush = 1'b1;
        vin = 1'b1;
        rin = 1'b1;
        din = 32'h4FF;
        tick();
        flush = 1'b0;
        vin = 1'b0;
        rin = 1'b0;
        chk("fl_count", 32'(cnt), 32'd0);
        chk("fl_valid", 32'(vout), 32'd0);
        chk("fl_ready", 32'(rdy_out), 32'd1);
        chk("fl_aempty", 32'(aempty), 32'd1);
        chk("fl_afull", 32'(afull), 32'd0);
        push_n(1, 32'hA5);
        drain_expect(1, 32'hA5, "fl_a5");

        // Asynchronous reset in mid-cycle with data stored.
        push_n(3, 32'h500);
        chk("ar_count3", 32'(cnt), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_count", 32'(cnt), 32'd0);
        chk("ar_valid", 32'(vout), 32'd0);
        chk("ar_ready", 32'(rdy_out), 32'd0);
        chk("ar_aempty", 32'(aempty), 32'd1);
        chk("ar_afull", 32'(afull), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("ar_ready_back", 32'(rdy_out), 32'd1);
        chk("ar_still_empty", 32'(vout), 32'd0);
        push_n(1, 32'h600);
        chk("ar_count1", 32'(cnt), 32'd1);
        drain_expect(1, 32'h600, "ar_new");
        chk("ar_end_empty", 32'(vout), 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
